bsg_reduce_segmented_accum: RTL and testbench

//  Multi-beat segmented reducer. Each accepted beat of segments_p*segment_width_p bits is reduced per segment.

---
 rtl/bsg_reduce_pkg.sv | 19 +
 rtl/bsg_segment_reduce_step.sv | 29 ++
 rtl/bsg_reduce_segmented_accum.sv | 94 +++++++++
 tb/tb_bsg_reduce_segmented_accum.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bsg_reduce_pkg.sv
// Shared types for the segmented reducer.
//   bsg_reduce_op_e    : reduction selected per packet
//   bsg_reduce_state_e : packet FSM states
package bsg_reduce_pkg;

    typedef enum logic [1:0] {
        e_red_xor = 2'd0,
        e_red_and = 2'd1,
        e_red_or  = 2'd2,
        e_red_nor = 2'd3
    } bsg_reduce_op_e;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_accum = 2'd1,
        e_done  = 2'd2
    } bsg_reduce_state_e;

endpackage

// File: rtl/bsg_segment_reduce_step.sv
// One-segment fold step (combinational).
//   data_i  : segment bits of the current beat
//   acc_i   : running accumulator bit for this segment
//   op_i    : reduction in effect for the packet
//   first_i : beat opens a packet, so the accumulator is re-seeded
//   acc_o   : accumulator bit after folding this beat
// NOR folds like OR; the inversion happens once, at the output register.
module bsg_segment_reduce_step
    import bsg_reduce_pkg::*;
#(
    parameter int segment_width_p = 4
) (
    input  logic [segment_width_p-1:0] data_i,
    input  logic                       acc_i,
    input  bsg_reduce_op_e             op_i,
    input  logic                       first_i,
    output logic                       acc_o
);

    always_comb begin
        acc_o = acc_i;
        case (op_i)
            e_red_xor: acc_o = (first_i ? 1'b0 : acc_i) ^ (^data_i);
            e_red_and: acc_o = (first_i ? 1'b1 : acc_i) & (&data_i);
            default:   acc_o = (first_i ? 1'b0 : acc_i) | (|data_i);
        endcase
    end

endmodule

// File: rtl/bsg_reduce_segmented_accum.sv
// Multi-beat segmented reducer: each beat is reduced per segment and folded
// into a running accumulator; the beat flagged last produces one result.
//   clk_i, reset_n_i : clock, async active-low reset
//   v_i/ready_o      : beat handshake (data_i, op_i, last_i)
//   v_o/yumi_i       : result handshake (data_o, count_o)
// op_i is only sampled on the first beat of a packet. count_o saturates.
module bsg_reduce_segmented_accum
    import bsg_reduce_pkg::*;
#(
    parameter int segments_p      = 4,
    parameter int segment_width_p = 4,
    parameter int beats_width_p   = 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  v_i,
    output logic                                  ready_o,
    input  logic [segments_p*segment_width_p-1:0] data_i,
    input  bsg_reduce_op_e                        op_i,
    input  logic                                  last_i,
    output logic                                  v_o,
    output logic [segments_p-1:0]                 data_o,
    output logic [beats_width_p-1:0]              count_o,
    input  logic                                  yumi_i
);

    bsg_reduce_state_e          state_r, state_n;
    bsg_reduce_op_e             op_r, op_cur;
    logic [segments_p-1:0]      acc_r, acc_n;
    logic [segments_p-1:0]      data_r;
    logic [beats_width_p-1:0]   count_r, count_n;
    logic                       accept, first;

    // ready/valid decode straight from the state register: no yumi->ready path
    assign ready_o = (state_r != e_done);
    assign v_o     = (state_r == e_done);
    assign data_o  = data_r;
    assign count_o = count_r;

    assign accept  = v_i & ready_o;
    assign first   = (state_r == e_idle);
    assign op_cur  = first ? op_i : op_r;

    for (genvar j = 0; j < segments_p; j++) begin : g_seg
        bsg_segment_reduce_step #(
            .segment_width_p(segment_width_p)
        ) u_step (
            .data_i  (data_i[j*segment_width_p +: segment_width_p]),
            .acc_i   (acc_r[j]),
            .op_i    (op_cur),
            .first_i (first),
            .acc_o   (acc_n[j])
        );
    end

    always_comb begin
        if (first)         count_n = beats_width_p'(1);
        else if (&count_r) count_n = count_r;
        else               count_n = count_r + beats_width_p'(1);
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle, e_accum: if (accept) state_n = last_i ? e_done : e_accum;
            e_done:          if (yumi_i) state_n = e_idle;
            default:         state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            op_r    <= e_red_xor;
            acc_r   <= '0;
            count_r <= '0;
            data_r  <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                op_r    <= op_cur;
                acc_r   <= acc_n;
                count_r <= count_n;
                if (last_i) data_r <= (op_cur == e_red_nor) ? ~acc_n : acc_n;
            end
        end
    end

    // yumi without a pending result is a protocol error upstream
    always @(posedge clk_i) begin
        if (reset_n_i && yumi_i) assert (v_o);
    end

endmodule

// File: tb/tb_bsg_reduce_segmented_accum.sv
module tb_bsg_reduce_segmented_accum;
    import bsg_reduce_pkg::*;

    localparam int SEG = 4, SW = 4, BW = 2;

    logic               clk_i = 0, reset_n_i = 0;
    logic               v_i = 0, ready_o, last_i = 0, v_o, yumi_i = 0;
    logic [SEG*SW-1:0]  data_i = '0;
    bsg_reduce_op_e     op_i = e_red_xor;
    logic [SEG-1:0]     data_o;
    logic [BW-1:0]      count_o;

    int n_assert = 0, n_fail = 0;
    logic [15:0] pkt_q[$];

    bsg_reduce_segmented_accum #(.segments_p(SEG), .segment_width_p(SW), .beats_width_p(BW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .data_i(data_i),
        .op_i(op_i), .last_i(last_i), .v_o(v_o), .data_o(data_o), .count_o(count_o), .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: per segment, look at every bit of that segment over the whole packet
    function automatic logic [3:0] ref_data(input bsg_reduce_op_e op);
        logic [3:0] r;
        for (int j = 0; j < SEG; j++) begin
            int ones = 0;
            bit all_set = 1;
            foreach (pkt_q[b]) begin
                ones += $countones(pkt_q[b][j*SW +: SW]);
                if (pkt_q[b][j*SW +: SW] != 4'hF) all_set = 0;
            end
            case (op)
                e_red_xor: r[j] = (ones % 2) == 1;
                e_red_and: r[j] = all_set;
                e_red_or:  r[j] = ones != 0;
                default:   r[j] = ones == 0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] ref_count();
        return (pkt_q.size() > 3) ? 2'd3 : 2'(pkt_q.size());
    endfunction

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    // drive one beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [15:0] d, input bsg_reduce_op_e op, input logic last);
        int k = 0;
        v_i = 1; data_i = d; op_i = op; last_i = last;
        while (!ready_o && k < 20) begin tick(); k++; end
        if (!ready_o) chk("ready_timeout", 0, 1);
        tick();
        v_i = 0; last_i = 0;
    endtask

    // send pkt_q; later beats carry a random op that must be ignored
    task automatic send_pkt(input bsg_reduce_op_e op, input bit bubbles);
        foreach (pkt_q[b]) begin
            bsg_reduce_op_e o = (b == 0) ? op : bsg_reduce_op_e'($urandom_range(0, 3));
            send_beat(pkt_q[b], o, b == pkt_q.size() - 1);
            if (bubbles && b != pkt_q.size() - 1 && $urandom_range(0, 2) == 0) tick();
        end
    endtask

    task automatic check_result(input string tag, input bsg_reduce_op_e op);
        chk({tag, "_v"}, v_o, 1);
        chk({tag, "_data"}, data_o, ref_data(op));
        chk({tag, "_count"}, count_o, ref_count());
    endtask

    task automatic take(input int hold, input bsg_reduce_op_e op);
        for (int i = 0; i < hold; i++) begin
            v_i = 1; data_i = 16'($urandom); last_i = 1;
            tick();
            chk("hold_ready", ready_o, 0);
            check_result("hold", op);
        end
        v_i = 0; last_i = 0;
        yumi_i = 1;
        tick();
        yumi_i = 0;
        chk("post_yumi_ready", ready_o, 1);
        chk("post_yumi_v", v_o, 0);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_v", v_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_data", data_o, 0);
        chk("rst_count", count_o, 0);
        #10 reset_n_i = 1;
        tick();

        // 1: XOR single beat
        pkt_q = '{16'hF731};
        send_pkt(e_red_xor, 0);
        check_result("t1", e_red_xor);
        chk("t1_const", {count_o, data_o}, {2'd1, 4'b0101});
        take(0, e_red_xor);

        // 2: AND three beats
        pkt_q = '{16'hFFFF, 16'hF0FF, 16'hFFF0};
        send_pkt(e_red_and, 0);
        chk("t2_const", {count_o, data_o}, {2'd3, 4'b1010});
        take(0, e_red_and);

        // 3: NOR, then a fresh NOR packet re-seeds the accumulator
        pkt_q = '{16'h0000, 16'h0100};
        send_pkt(e_red_nor, 0);
        chk("t3a_const", {count_o, data_o}, {2'd2, 4'b1011});
        take(0, e_red_nor);
        pkt_q = '{16'h0000};
        send_pkt(e_red_nor, 0);
        chk("t3b_const", {count_o, data_o}, {2'd1, 4'b1111});

        // 4: backpressure with v_i high and changing data
        take(5, e_red_nor);

        // 5: reset mid-packet discards the partial packet
        send_beat(16'hFFFF, e_red_and, 0);
        send_beat(16'h1234, e_red_and, 0);
        #2 reset_n_i = 0;
        #1;
        chk("t5_v", v_o, 0);
        chk("t5_count", count_o, 0);
        chk("t5_ready", ready_o, 1);
        #3 reset_n_i = 1;
        tick();
        chk("t5_idle_v", v_o, 0);
        pkt_q = '{16'h0001};
        send_pkt(e_red_xor, 0);
        chk("t5_const", {count_o, data_o}, {2'd1, 4'b0001});
        take(0, e_red_xor);

        // 6: OR, saturating count
        pkt_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
        send_pkt(e_red_or, 0);
        chk("t6_const", {count_o, data_o}, {2'd3, 4'b1000});
        take(1, e_red_or);

        // random packets against the reference model
        for (int p = 0; p < 40; p++) begin
            bsg_reduce_op_e op = bsg_reduce_op_e'($urandom_range(0, 3));
            int len = $urandom_range(1, 6);
            pkt_q.delete();
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 3))
                    0:       pkt_q.push_back(16'hFFFF);
                    1:       pkt_q.push_back(16'h0000);
                    default: pkt_q.push_back(16'($urandom));
                endcase
            end
            send_pkt(op, 1);
            check_result("rand", op);
            take($urandom_range(0, 3), op);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
